// File: rtl/mdr_pkg.sv
// ----------------------------------------------------------------------------
// mdr_pkg : responder states and ld_str encodings shared with the MDR | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mdr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic LD  = 1'b0;
  localparam logic STR = 1'b1;

  localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_data_responder_wait_counter.sv
// ----------------------------------------------------------------------------
// wait_counter : loadable down-counter that stops at zero; done while zero | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wait_counter
  import mdr_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_data_responder.sv
// ----------------------------------------------------------------------------
// mem_data_responder : word-addressed store with wait states and a held
// valid/ack response feeding the memory data register cache_in | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_data_responder
  import mdr_pkg::*;
#(
  parameter int n           = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              ld_str,
  input  logic [ADDR_W-1:0] addr,
  input  logic [n-1:0]      wdata,
  output logic [n-1:0]      rdata,
  output logic              resp_valid,
  output logic              resp_err,
  input  logic              resp_ack
);

  localparam int               c_depth     = 2 ** (ADDR_W - 2);
  localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(WAIT_CYCLES);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [n-1:0]        wdata_q;
  logic                ld_str_q;
  logic [n-1:0]        rdata_q;
  logic                resp_err_q;
  logic [n-1:0]        mem_q [c_depth];

  logic                w_accept;
  logic                w_cnt_done;
  logic                w_enter_resp;
  logic                w_misaligned;
  logic [ADDR_W-3:0]   w_word;

  assign req_ready    = (state_q == IDLE) && !clr;
  assign w_accept     = req_valid && req_ready;
  assign w_misaligned = (addr_q[1:0] != 2'b00);
  assign w_word       = addr_q[ADDR_W-1:2];
  assign w_enter_resp = (state_q == WAIT) && w_cnt_done && !clr;

  // WAIT always lasts WAIT_CYCLES+1 cycles (counter loaded on acceptance,
  // exit once it reads zero), so the response appears k+WAIT_CYCLES+1 edges
  // after acceptance at edge k, including the zero-wait build.
  wait_counter u_wait_counter (
    .clk     (clk),
    .clr     (clr),
    .load_i  (w_accept),
    .value_i (c_wait_load),
    .done_o  (w_cnt_done)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      ld_str_q   <= LD;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_accept) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            ld_str_q <= ld_str;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (w_cnt_done) begin
            state_q    <= RESP;
            resp_err_q <= w_misaligned;
            if (!w_misaligned && (ld_str_q == LD)) begin
              rdata_q <= mem_q[w_word];
            end
          end
        end
        RESP: begin
          if (resp_ack) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; a store commits only on RESP entry.
  always_ff @(posedge clk) begin
    if (w_enter_resp && !w_misaligned && (ld_str_q == STR)) begin
      mem_q[w_word] <= wdata_q;
    end
  end

  assign rdata      = rdata_q;
  assign resp_err   = resp_err_q;
  assign resp_valid = (state_q == RESP);

endmodule

`default_nettype wire

// File: tb/tb_mem_data_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_data_responder : directed plus random load/store traffic against a
// word-map reference model, for WAIT_CYCLES=2 and WAIT_CYCLES=0 builds | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_data_responder;
  import mdr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;

  logic        a_req_valid, a_req_ready, a_ld_str, a_resp_valid, a_resp_err, a_resp_ack;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;

  logic        z_req_valid, z_req_ready, z_ld_str, z_resp_valid, z_resp_err, z_resp_ack;
  logic [7:0]  z_addr;
  logic [31:0] z_wdata, z_rdata;

  mem_data_responder #(.n(32), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .clr(clr), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .ld_str(a_ld_str), .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
    .resp_valid(a_resp_valid), .resp_err(a_resp_err), .resp_ack(a_resp_ack)
  );

  mem_data_responder #(.n(32), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .clr(clr), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .ld_str(z_ld_str), .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata),
    .resp_valid(z_resp_valid), .resp_err(z_resp_err), .resp_ack(z_resp_ack)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: word contents keyed by (build, word index), last load data per build.
  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_rd  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit z);
    return z ? z_req_ready : a_req_ready;
  endfunction
  function automatic logic vld(input bit z);
    return z ? z_resp_valid : a_resp_valid;
  endfunction
  function automatic logic err(input bit z);
    return z ? z_resp_err : a_resp_err;
  endfunction
  function automatic logic [31:0] rd(input bit z);
    return z ? z_rdata : a_rdata;
  endfunction

  task automatic drive(input bit z, input logic v, input logic st,
                       input logic [7:0] a, input logic [31:0] d);
    if (z) begin
      z_req_valid = v; z_ld_str = st; z_addr = a; z_wdata = d;
    end else begin
      a_req_valid = v; a_ld_str = st; a_addr = a; a_wdata = d;
    end
  endtask

  task automatic set_ack(input bit z, input logic v);
    if (z) z_resp_ack = v;
    else   a_resp_ack = v;
  endtask

  // Call just after a rising edge with the target responder idle; returns the same way.
  task automatic xact(input bit z, input logic st, input logic [7:0] a,
                      input logic [31:0] d, input int ack_dly, input string tag);
    int          lat;
    int          key;
    int          wc;
    logic        exp_err;
    wc  = z ? 0 : 2;
    key = (z ? 256 : 0) + int'(a[7:2]);

    drive(z, 1'b1, st, a, d);
    @(negedge clk);
    check({tag, " ready_before"}, 32'(rdy(z)), 32'd1);
    @(posedge clk); #1;
    drive(z, 1'b0, ~st, a ^ 8'($urandom), $urandom);

    lat = 0;
    @(negedge clk);
    while (!vld(z) && lat <= 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(wc + 1));

    if (a[1:0] != 2'b00) begin
      exp_err = 1'b1;
    end else begin
      exp_err = 1'b0;
      if (st == STR) mdl_mem[key] = d;
      else           mdl_rd[z]    = mdl_mem[key];
    end
    check({tag, " resp_err"}, 32'(err(z)), 32'(exp_err));
    check({tag, " rdata"}, rd(z), mdl_rd[z]);
    check({tag, " ready_in_resp"}, 32'(rdy(z)), 32'd0);

    for (int i = 0; i < ack_dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " held_valid"}, 32'(vld(z)), 32'd1);
      check({tag, " held_rdata"}, rd(z), mdl_rd[z]);
      check({tag, " held_ready"}, 32'(rdy(z)), 32'd0);
    end

    set_ack(z, 1'b1);
    @(posedge clk); #1;
    set_ack(z, 1'b0);
    @(negedge clk);
    check({tag, " valid_after_ack"}, 32'(vld(z)), 32'd0);
    check({tag, " ready_after_ack"}, 32'(rdy(z)), 32'd1);
    check({tag, " rdata_after_ack"}, rd(z), mdl_rd[z]);
    check({tag, " err_after_ack"}, 32'(err(z)), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          z;
    logic        st;
    logic [7:0]  a;
    int          key;
    int          idx;

    clr = 1'b1;
    drive(1'b0, 1'b0, LD, 8'h00, 32'h0);
    drive(1'b1, 1'b0, LD, 8'h00, 32'h0);
    a_resp_ack = 1'b0;
    z_resp_ack = 1'b0;
    mdl_rd[0]  = 32'h0;
    mdl_rd[1]  = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      check("rst ready", 32'(rdy(b[0])), 32'd0);
      check("rst valid", 32'(vld(b[0])), 32'd0);
      check("rst err",   32'(err(b[0])), 32'd0);
      check("rst rdata", rd(b[0]),        32'h0);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("post_rst ready a", 32'(rdy(1'b0)), 32'd1);
    check("post_rst ready z", 32'(rdy(1'b1)), 32'd1);
    @(posedge clk); #1;

    xact(1'b0, STR, 8'h10, 32'hDEADBEEF, 0, "st10");
    xact(1'b0, LD,  8'h10, 32'h0,        0, "ld10");
    xact(1'b0, LD,  8'h13, 32'h0,        1, "mis_ld");
    xact(1'b0, STR, 8'h11, 32'hCAFEF00D, 0, "mis_st");
    xact(1'b0, LD,  8'h10, 32'h0,        5, "held_ld");
    xact(1'b0, STR, 8'h20, 32'h0,        0, "pre20");

    // Abort a store while it sits in WAIT.
    drive(1'b0, 1'b1, STR, 8'h20, 32'h12345678);
    @(negedge clk);
    check("abort ready", 32'(rdy(1'b0)), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, LD, 8'h00, 32'h0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    mdl_rd[0] = 32'h0;
    mdl_rd[1] = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort no_valid", 32'(vld(1'b0)), 32'd0);
      check("abort ready_idle", 32'(rdy(1'b0)), 32'd1);
      @(posedge clk); #1;
    end
    check("abort rdata_cleared", rd(1'b0), 32'h0);
    xact(1'b0, LD, 8'h20, 32'h0, 0, "ld20_after_abort");

    xact(1'b1, STR, 8'h44, 32'hA5A5_0F0F, 0, "z_st44");
    xact(1'b1, LD,  8'h44, 32'h0,         2, "z_ld44");

    for (int n_it = 0; n_it < 40; n_it++) begin
      z   = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 7));
      a   = 8'(idx * 4);
      if ($urandom_range(0, 4) == 0) a = a + 8'($urandom_range(1, 3));
      st  = 1'($urandom_range(0, 1));
      key = (z ? 256 : 0) + idx;
      if (st == LD && a[1:0] == 2'b00 && !mdl_mem.exists(key)) st = STR;
      xact(z, st, a, $urandom, int'($urandom_range(0, 3)), z ? "rnd_z" : "rnd_a");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
